// File: rtl/uart_frame_packer_if.sv
// Byte-stream input and frame output bundle for uart_frame_packer.
// The master side feeds payload bytes and watches the frame strobe;
// the slave side is the packer itself.
`timescale 1ns/1ps
interface uart_frame_packer_if #(
    parameter int BYTE_SIZE      = 8,
    parameter int FULL_DATA_SIZE = 40
) ();
    logic [BYTE_SIZE-1:0]      in_byte;
    logic                      in_byte_valid;
    logic                      in_last;
    logic                      in_byte_ready;
    logic [FULL_DATA_SIZE-1:0] full_data;
    logic                      out_valid;
    logic                      busy;

    modport master (
        output in_byte, in_byte_valid, in_last,
        input  in_byte_ready, full_data, out_valid, busy
    );

    modport slave (
        input  in_byte, in_byte_valid, in_last,
        output in_byte_ready, full_data, out_valid, busy
    );
endinterface

// File: rtl/uart_frame_packer.sv
// uart_frame_packer: gathers payload bytes from a valid/ready stream and
// packs them into {header, len, payload..., xor checksum}. The frame is
// strobed into uart_tx, then the packer holds off for a fixed gap so the
// transmitter finishes shifting before the next frame can be launched.
`timescale 1ns/1ps
module uart_frame_packer #(
    parameter int                FULL_DATA_SIZE   = 40,
    parameter int                BYTE_SIZE        = 8,
    parameter logic [BYTE_SIZE-1:0] HEADER_BYTE   = 8'h00,
    parameter int                OUT_VALID_CYCLES = 2,
    parameter int                TX_GAP_CYCLES    = 1000
) (
    input logic              CLK,
    input logic              RST,
    uart_frame_packer_if.slave bus
);

    localparam int NBYTES        = FULL_DATA_SIZE / BYTE_SIZE;
    localparam int PAYLOAD_BYTES = NBYTES - 3;
    localparam int CNT_W         = $clog2(PAYLOAD_BYTES + 1);
    localparam int GAP_W         = $clog2(TX_GAP_CYCLES + 1);
    localparam int OV_W          = $clog2(OUT_VALID_CYCLES + 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        LAUNCH  = 2'd1,
        GAP     = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]          count;
    logic [BYTE_SIZE-1:0]      payload [PAYLOAD_BYTES];
    logic [FULL_DATA_SIZE-1:0] full_data_q;
    logic [OV_W-1:0]           ov_cnt;
    logic [GAP_W-1:0]          gap_cnt;

    logic                      accept;
    logic                      frame_done;
    logic [FULL_DATA_SIZE-1:0] frame_next;
    logic [BYTE_SIZE-1:0]      frame_len;
    logic [BYTE_SIZE-1:0]      frame_chk;
    logic [BYTE_SIZE-1:0]      frame_slot;

    // A byte lands when offered while collecting; it closes the frame if
    // flagged last or if it fills the final payload slot.
    always_comb begin
        accept     = bus.in_byte_valid & (state == COLLECT) & ~RST;
        frame_done = accept & (bus.in_last | (count == CNT_W'(PAYLOAD_BYTES - 1)));
    end

    // Build the frame as it would look with the incoming byte already in its
    // slot, so the closing edge can register it with the right len and chk.
    always_comb begin
        frame_next = '0;
        frame_slot = '0;
        frame_len  = BYTE_SIZE'(count) + BYTE_SIZE'(1);
        frame_chk  = frame_len;
        frame_next[FULL_DATA_SIZE-1 -: BYTE_SIZE]           = HEADER_BYTE;
        frame_next[FULL_DATA_SIZE-1-BYTE_SIZE -: BYTE_SIZE] = frame_len;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            frame_slot = (count == CNT_W'(i)) ? bus.in_byte : payload[i];
            frame_next[FULL_DATA_SIZE-1-(i+2)*BYTE_SIZE -: BYTE_SIZE] = frame_slot;
            frame_chk = frame_chk ^ frame_slot;
        end
        frame_next[BYTE_SIZE-1:0] = frame_chk;
    end

    // State register; reset aborts whatever frame is in progress.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; ready is withheld during reset.
    always_comb begin
        state_next        = state;
        bus.in_byte_ready = (state == COLLECT) & ~RST;
        bus.out_valid     = (state == LAUNCH);
        bus.busy          = (state != COLLECT);
        bus.full_data     = full_data_q;
        case (state)
            COLLECT: if (frame_done)               state_next = LAUNCH;
            LAUNCH:  if (ov_cnt <= OV_W'(1))       state_next = GAP;
            GAP:     if (gap_cnt <= GAP_W'(1))     state_next = COLLECT;
            default:                               state_next = COLLECT;
        endcase
    end

    // Payload capture, frame register and the strobe/gap down-counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count       <= '0;
            full_data_q <= '0;
            ov_cnt      <= '0;
            gap_cnt     <= '0;
            for (int i = 0; i < PAYLOAD_BYTES; i++) begin
                payload[i] <= '0;
            end
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
                            if (count == CNT_W'(i)) begin
                                payload[i] <= bus.in_byte;
                            end
                        end
                        count <= count + CNT_W'(1);
                        if (frame_done) begin
                            full_data_q <= frame_next;
                            ov_cnt      <= OV_W'(OUT_VALID_CYCLES);
                        end
                    end
                end
                LAUNCH: begin
                    ov_cnt <= ov_cnt - OV_W'(1);
                    if (state_next == GAP) begin
                        gap_cnt <= GAP_W'(TX_GAP_CYCLES);
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - GAP_W'(1);
                    if (state_next == COLLECT) begin
                        count <= '0;
                        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
                            payload[i] <= '0;
                        end
                    end
                end
                default: begin
                    count <= '0;
                end
            endcase
        end
    end

endmodule
